// File: rtl/gmii2xgmii_packer.sv
// GMII-to-XGMII lane packer: frames a byte-wide GMII stream into LANES-wide
// XGMII words with /S/ /T/ /E/ /I/ insertion and a minimum inter-frame gap.
module gmii2xgmii_packer #(
    parameter int LANES      = 8,
    parameter int MIN_IFG    = 12,
    parameter int START_MODE = 0
) (
    input  logic                 gmii_clk,
    input  logic                 sys_rst,
    input  logic                 gmii_dv,
    input  logic                 gmii_er,
    input  logic [7:0]           gmii_rxd,
    output logic [LANES-1:0]     xgmii_rxc,
    output logic [8*LANES-1:0]   xgmii_rxd,
    output logic                 xgmii_valid,
    output logic                 drop_pulse
);

    localparam int PTR_W = $clog2(LANES);
    localparam int CNT_W = $clog2(MIN_IFG + 1);
    localparam logic [CNT_W-1:0] IFG_MAX  = CNT_W'(MIN_IFG);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(LANES - 1);

    // Symbols carry the control flag in bit 8.
    localparam logic [8:0] SYM_S = 9'h1FB;
    localparam logic [8:0] SYM_T = 9'h1FD;
    localparam logic [8:0] SYM_E = 9'h1FE;
    localparam logic [8:0] SYM_I = 9'h107;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_TERM,
        S_IFG,
        S_DROP
    } state_t;

    state_t                     state_q, state_d;
    logic                       stg_vld_q, stg_vld_d;
    logic [8:0]                 stg_q, stg_d;
    logic [8:0]                 hold_q, hold_d;
    logic [PTR_W-1:0]           ptr_q, ptr_d;
    logic [LANES-1:0][8:0]      asm_q, asm_d;
    logic [LANES-1:0][8:0]      word;
    logic [LANES-1:0][7:0]      rxd_q, rxd_d;
    logic [LANES-1:0]           rxc_q, rxc_d;
    logic                       valid_q, valid_d;
    logic                       drop_q, drop_d;
    logic [CNT_W-1:0]           ifg_cnt_q, ifg_cnt_d, ifg_cnt_inc;
    logic                       armed_q, armed_d;
    logic [8:0]                 data_sym;

    assign data_sym    = gmii_er ? SYM_E : {1'b0, gmii_rxd};
    assign ifg_cnt_inc = (ifg_cnt_q < IFG_MAX) ? ifg_cnt_q + 1'b1 : ifg_cnt_q;

    // Framing FSM: decides what enters the stage register each cycle.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path infers a latch.
        state_d   = state_q;
        stg_vld_d = 1'b0;
        stg_d     = SYM_I;
        hold_d    = hold_q;
        ifg_cnt_d = ifg_cnt_q;
        armed_d   = armed_q | ~gmii_dv;
        drop_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!gmii_dv) begin
                    ifg_cnt_d = ifg_cnt_inc;
                end else if (armed_q) begin
                    if (ifg_cnt_q >= IFG_MAX) begin
                        stg_vld_d = 1'b1;
                        stg_d     = SYM_S;
                        if (START_MODE != 0) hold_d = data_sym;
                        state_d   = S_DATA;
                    end else begin
                        state_d   = S_DROP;
                    end
                end
            end
            S_DATA: begin
                stg_vld_d = 1'b1;
                if (gmii_dv) begin
                    if (START_MODE == 0) begin
                        stg_d  = data_sym;
                    end else begin
                        stg_d  = hold_q;
                        hold_d = data_sym;
                    end
                end else begin
                    ifg_cnt_d = CNT_W'(1);
                    if (START_MODE == 0) begin
                        stg_d   = SYM_T;
                        state_d = S_IFG;
                    end else begin
                        stg_d   = hold_q;
                        state_d = S_TERM;
                    end
                end
            end
            S_TERM: begin
                stg_vld_d = 1'b1;
                stg_d     = SYM_T;
                if (gmii_dv) begin
                    state_d   = S_DROP;
                end else begin
                    ifg_cnt_d = ifg_cnt_inc;
                    state_d   = S_IFG;
                end
            end
            S_IFG: begin
                if (gmii_dv) begin
                    state_d   = S_DROP;
                end else begin
                    ifg_cnt_d = ifg_cnt_inc;
                    state_d   = S_IDLE;
                end
            end
            S_DROP: begin
                if (!gmii_dv) begin
                    drop_d    = 1'b1;
                    ifg_cnt_d = CNT_W'(1);
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Lane assembly: place the staged symbol, pad after /T/, emit when full.
    always_comb begin
        word    = asm_q;
        asm_d   = asm_q;
        ptr_d   = ptr_q;
        rxd_d   = rxd_q;
        rxc_d   = rxc_q;
        valid_d = 1'b0;

        if (stg_vld_q) begin
            word[ptr_q] = stg_q;
            if (stg_q == SYM_T) begin
                for (int i = 0; i < LANES; i++) begin
                    if (i > int'(ptr_q)) word[i] = SYM_I;
                end
            end
            if (stg_q == SYM_T || ptr_q == PTR_LAST) begin
                for (int i = 0; i < LANES; i++) begin
                    rxd_d[i] = word[i][7:0];
                    rxc_d[i] = word[i][8];
                end
                valid_d = 1'b1;
                ptr_d   = '0;
            end else begin
                asm_d   = word;
                ptr_d   = ptr_q + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge gmii_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q   <= S_IDLE;
            stg_vld_q <= 1'b0;
            ptr_q     <= '0;
            rxd_q     <= {LANES{8'h07}};
            rxc_q     <= '1;
            valid_q   <= 1'b0;
            drop_q    <= 1'b0;
            ifg_cnt_q <= IFG_MAX;
            armed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            stg_vld_q <= stg_vld_d;
            ptr_q     <= ptr_d;
            rxd_q     <= rxd_d;
            rxc_q     <= rxc_d;
            valid_q   <= valid_d;
            drop_q    <= drop_d;
            ifg_cnt_q <= ifg_cnt_d;
            armed_q   <= armed_d;
        end
    end

    // NOTE: payload registers are left unreset; stg_vld_q and ptr_q already qualify them.
    always_ff @(posedge gmii_clk) begin
        stg_q  <= stg_d;
        hold_q <= hold_d;
        asm_q  <= asm_d;
    end

    assign xgmii_rxc   = rxc_q;
    assign xgmii_rxd   = rxd_q;
    assign xgmii_valid = valid_q;
    assign drop_pulse  = drop_q;

endmodule

// File: tb/tb_gmii2xgmii_packer.sv
// Scoreboard bench for gmii2xgmii_packer: an 8-lane/mode-0 and a 4-lane/mode-1
// instance share one randomized GMII stream and are checked against a symbol-list model.
module tb_gmii2xgmii_packer;

    logic        gmii_clk = 1'b0;
    logic        sys_rst;
    logic        gmii_dv;
    logic        gmii_er;
    logic [7:0]  gmii_rxd;

    logic [7:0]  rxc8;
    logic [63:0] rxd8;
    logic        valid8, drop8;
    logic [3:0]  rxc4;
    logic [31:0] rxd4;
    logic        valid4, drop4;

    always #5 gmii_clk = ~gmii_clk;

    gmii2xgmii_packer #(.LANES(8), .MIN_IFG(12), .START_MODE(0)) u_dut8 (
        .gmii_clk    (gmii_clk),
        .sys_rst     (sys_rst),
        .gmii_dv     (gmii_dv),
        .gmii_er     (gmii_er),
        .gmii_rxd    (gmii_rxd),
        .xgmii_rxc   (rxc8),
        .xgmii_rxd   (rxd8),
        .xgmii_valid (valid8),
        .drop_pulse  (drop8)
    );

    gmii2xgmii_packer #(.LANES(4), .MIN_IFG(12), .START_MODE(1)) u_dut4 (
        .gmii_clk    (gmii_clk),
        .sys_rst     (sys_rst),
        .gmii_dv     (gmii_dv),
        .gmii_er     (gmii_er),
        .gmii_rxd    (gmii_rxd),
        .xgmii_rxc   (rxc4),
        .xgmii_rxd   (rxd4),
        .xgmii_valid (valid4),
        .drop_pulse  (drop4)
    );

    typedef struct packed {
        logic [7:0]  c;
        logic [63:0] d;
    } word_t;

    word_t      q8[$];
    word_t      q4[$];
    int         dq8 = 0;
    int         dq4 = 0;
    int         n_chk = 0;
    int         n_err = 0;
    logic [7:0] fb[0:127];
    logic       fe[0:127];
    bit         fresh;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Frame as a symbol list: /S/, payload (mode 0 loses byte 0), /T/, /I/ pad to a word.
    task automatic model(input int lanes, input int mode, input int n);
        logic [8:0] sym[$];
        word_t      w;
        sym.push_back(9'h1FB);
        for (int k = (mode == 0) ? 1 : 0; k < n; k++)
            sym.push_back(fe[k] ? 9'h1FE : {1'b0, fb[k]});
        sym.push_back(9'h1FD);
        while (sym.size() % lanes != 0) sym.push_back(9'h107);
        for (int base = 0; base < sym.size(); base += lanes) begin
            w = '0;
            for (int i = 0; i < lanes; i++) begin
                w.c[i]        = sym[base + i][8];
                w.d[8*i +: 8] = sym[base + i][7:0];
            end
            if (lanes == 8) q8.push_back(w);
            else            q4.push_back(w);
        end
    endtask

    task automatic tick(input logic dv, input logic er, input logic [7:0] d);
        @(negedge gmii_clk);
        gmii_dv  = dv;
        gmii_er  = er;
        gmii_rxd = d;
    endtask

    // Idle cycles carry random er/rxd, which must be ignored while dv is low.
    task automatic idle(input int cycles);
        repeat (cycles) tick(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
    endtask

    task automatic rand_bytes(input int n, input bit er_en);
        for (int k = 0; k < n; k++) begin
            fb[k] = 8'($urandom);
            fe[k] = er_en && (k > 0) && ($urandom_range(0, 15) == 0);
        end
    endtask

    task automatic frame(input int n, input int gap);
        bit acc;
        idle(gap);
        acc   = (gap >= 12) || (fresh && gap >= 1);
        fresh = 1'b0;
        if (acc) begin
            model(8, 0, n);
            model(4, 1, n);
        end else begin
            dq8++;
            dq4++;
        end
        for (int k = 0; k < n; k++) tick(1'b1, fe[k], fb[k]);
    endtask

    always @(negedge gmii_clk) begin
        if (!sys_rst) begin
            if (valid8) begin
                if (q8.size() == 0) check("word8_extra", {71'b0, valid8}, 72'd0);
                else                check("word8", {rxc8, rxd8}, q8.pop_front());
            end
            if (valid4) begin
                if (q4.size() == 0) check("word4_extra", {71'b0, valid4}, 72'd0);
                else                check("word4", {4'h0, rxc4, 32'h0, rxd4}, q4.pop_front());
            end
            if (drop8) begin
                check("drop8", {71'b0, drop8}, {71'b0, dq8 > 0});
                if (dq8 > 0) dq8--;
            end
            if (drop4) begin
                check("drop4", {71'b0, drop4}, {71'b0, dq4 > 0});
                if (dq4 > 0) dq4--;
            end
        end
    end

    initial begin
        int n, gap;
        fresh    = 1'b1;
        sys_rst  = 1'b1;
        gmii_dv  = 1'b0;
        gmii_er  = 1'b0;
        gmii_rxd = 8'h00;
        repeat (3) @(negedge gmii_clk);
        check("rst_rxc8",   {64'b0, rxc8}, 72'hFF);
        check("rst_rxd8",   {8'b0, rxd8}, {8'h00, {8{8'h07}}});
        check("rst_valid8", {71'b0, valid8}, 72'd0);
        check("rst_drop8",  {71'b0, drop8}, 72'd0);
        check("rst_rxc4",   {68'b0, rxc4}, 72'hF);
        check("rst_rxd4",   {40'b0, rxd4}, {40'h0, {4{8'h07}}});
        check("rst_valid4", {71'b0, valid4}, 72'd0);
        sys_rst = 1'b0;

        // Preamble-like frame: 55 x7, D5.
        for (int k = 0; k < 7; k++) begin fb[k] = 8'h55; fe[k] = 1'b0; end
        fb[7] = 8'hD5; fe[7] = 1'b0;
        frame(8, 3);

        // 64-byte frame, then one with an error on byte 20.
        rand_bytes(64, 1'b0);
        frame(64, 12);
        rand_bytes(64, 1'b0);
        fe[20] = 1'b1;
        frame(64, 15);

        // Short gaps are dropped; exactly MIN_IFG is accepted.
        rand_bytes(30, 1'b0);
        frame(30, 5);
        rand_bytes(20, 1'b0);
        frame(20, 12);
        rand_bytes(20, 1'b0);
        frame(20, 11);
        rand_bytes(20, 1'b0);
        frame(20, 12);

        // One-cycle dv glitch, then AA BB CC DD.
        fb[0] = 8'h3C; fe[0] = 1'b0;
        frame(1, 12);
        fb[0] = 8'hAA; fb[1] = 8'hBB; fb[2] = 8'hCC; fb[3] = 8'hDD;
        for (int k = 0; k < 4; k++) fe[k] = 1'b0;
        frame(4, 12);

        // Back-to-back gaps of 1 and 2 are dropped.
        rand_bytes(10, 1'b0);
        frame(10, 1);
        rand_bytes(10, 1'b0);
        frame(10, 13);
        rand_bytes(10, 1'b0);
        frame(10, 2);

        for (int f = 0; f < 24; f++) begin
            n = $urandom_range(1, 70);
            case ($urandom_range(0, 4))
                0:       gap = 12;
                1:       gap = 11;
                2:       gap = $urandom_range(1, 10);
                default: gap = $urandom_range(13, 20);
            endcase
            rand_bytes(n, 1'b1);
            frame(n, gap);
        end

        // Reset two bytes into an accepted frame with dv held high throughout.
        idle(14);
        tick(1'b1, 1'b0, 8'h11);
        tick(1'b1, 1'b0, 8'h22);
        #2 sys_rst = 1'b1;
        #1;
        check("midrst_valid8", {71'b0, valid8}, 72'd0);
        check("midrst_rxc8",   {64'b0, rxc8}, 72'hFF);
        check("midrst_rxd8",   {8'b0, rxd8}, {8'h00, {8{8'h07}}});
        check("midrst_rxc4",   {68'b0, rxc4}, 72'hF);
        check("midrst_rxd4",   {40'b0, rxd4}, {40'h0, {4{8'h07}}});
        repeat (2) @(negedge gmii_clk);
        sys_rst = 1'b0;
        fresh   = 1'b1;
        repeat (5) tick(1'b1, 1'b0, 8'($urandom));
        rand_bytes(20, 1'b1);
        frame(20, 3);

        idle(30);
        check("left8",  72'(q8.size()), 72'd0);
        check("left4",  72'(q4.size()), 72'd0);
        check("ldrop8", 72'(dq8), 72'd0);
        check("ldrop4", 72'(dq4), 72'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
